itcm_arb: RTL and testbench

ITCM_ARB -- requirements
Module: itcm_arb

---
 rtl/itcm_arb.sv | 158 +++++++++++++++
 tb/tb_itcm_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/itcm_arb.sv
// ITCM arbiter: IFU/LSU share one single-port ITCM RAM, one outstanding transaction, LSU priority.
// Define ITCM_ARB_STARVE_EN to add a counter that forces an IFU grant after STARVE_MAX lost arbitrations.
module itcm_arb #(
  parameter int AW         = 16,
  parameter int RAW        = 14,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ifu2itcm_cmd_valid,
  output logic           ifu2itcm_cmd_ready,
  input  logic           ifu2itcm_cmd_read,
  input  logic [AW-1:0]  ifu2itcm_cmd_addr,
  input  logic [MW-1:0]  ifu2itcm_cmd_wmask,
  input  logic [DW-1:0]  ifu2itcm_cmd_wdata,
  output logic           ifu2itcm_rsp_valid,
  input  logic           ifu2itcm_rsp_ready,
  output logic [DW-1:0]  ifu2itcm_rsp_rdata,
  input  logic           lsu2itcm_cmd_valid,
  output logic           lsu2itcm_cmd_ready,
  input  logic           lsu2itcm_cmd_read,
  input  logic [AW-1:0]  lsu2itcm_cmd_addr,
  input  logic [MW-1:0]  lsu2itcm_cmd_wmask,
  input  logic [DW-1:0]  lsu2itcm_cmd_wdata,
  output logic           lsu2itcm_rsp_valid,
  input  logic           lsu2itcm_rsp_ready,
  output logic [DW-1:0]  lsu2itcm_rsp_rdata,
  output logic           itcm_ram_cs,
  output logic           itcm_ram_we,
  output logic [RAW-1:0] itcm_ram_addr,
  output logic [MW-1:0]  itcm_ram_wem,
  output logic [DW-1:0]  itcm_ram_din,
  input  logic [DW-1:0]  itcm_ram_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RSP = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_r, state_nxt_s;
  logic            owner_r;   // 1 = LSU owns the pending response
  logic            read_r;
  logic [DW-1:0]   hold_r;
  logic            pending_s, rsp_hs_s, can_accept_s, starve_force_s;
  logic            ifu_acc_s, lsu_acc_s, accept_s, win_read_s;
  logic [DW-1:0]   rsp_data_s;
  logic            unused_s;

  assign pending_s    = (state_r == RSP) || (state_r == HOLD);
  assign rsp_hs_s     = pending_s & (owner_r ? lsu2itcm_rsp_ready : ifu2itcm_rsp_ready);
  // rst_n gating keeps ready/cs low while reset is held
  assign can_accept_s = rst_n & (~pending_s | rsp_hs_s);

`ifdef ITCM_ARB_STARVE_EN
  logic [3:0] starve_cnt_r;

  assign starve_force_s = (starve_cnt_r >= 4'(STARVE_MAX));
  assign unused_s       = ^{ifu2itcm_cmd_addr[1:0], lsu2itcm_cmd_addr[1:0]};

  // Starvation counter: counts IFU losses to LSU, cleared when IFU wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (ifu_acc_s) begin
      starve_cnt_r <= 4'd0;
    end else if (ifu2itcm_cmd_valid && lsu_acc_s && (starve_cnt_r != 4'd15)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign starve_force_s = 1'b0;
  assign unused_s       = ^{ifu2itcm_cmd_addr[1:0], lsu2itcm_cmd_addr[1:0], 4'(STARVE_MAX)};
`endif

  // Each ready depends only on the other requester's valid, never its own
  assign lsu2itcm_cmd_ready = can_accept_s & ~(starve_force_s & ifu2itcm_cmd_valid);
  assign ifu2itcm_cmd_ready = can_accept_s & (~lsu2itcm_cmd_valid | starve_force_s);
  assign lsu_acc_s          = lsu2itcm_cmd_valid & lsu2itcm_cmd_ready;
  assign ifu_acc_s          = ifu2itcm_cmd_valid & ifu2itcm_cmd_ready;
  assign accept_s           = lsu_acc_s | ifu_acc_s;

  // RAM command mux from the accepted requester
  always_comb begin
    win_read_s    = 1'b1;
    itcm_ram_addr = {RAW{1'b0}};
    itcm_ram_din  = {DW{1'b0}};
    itcm_ram_wem  = {MW{1'b0}};
    if (lsu_acc_s) begin
      win_read_s    = lsu2itcm_cmd_read;
      itcm_ram_addr = lsu2itcm_cmd_addr[AW-1:2];
      itcm_ram_din  = lsu2itcm_cmd_wdata;
      itcm_ram_wem  = lsu2itcm_cmd_read ? {MW{1'b0}} : lsu2itcm_cmd_wmask;
    end else if (ifu_acc_s) begin
      win_read_s    = ifu2itcm_cmd_read;
      itcm_ram_addr = ifu2itcm_cmd_addr[AW-1:2];
      itcm_ram_din  = ifu2itcm_cmd_wdata;
      itcm_ram_wem  = ifu2itcm_cmd_read ? {MW{1'b0}} : ifu2itcm_cmd_wmask;
    end else begin
      win_read_s    = 1'b1;
    end
  end

  assign itcm_ram_cs = accept_s;
  assign itcm_ram_we = accept_s & ~win_read_s;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? RSP : IDLE;
      RSP:     state_nxt_s = rsp_hs_s ? (accept_s ? RSP : IDLE) : HOLD;
      HOLD:    state_nxt_s = rsp_hs_s ? (accept_s ? RSP : IDLE) : HOLD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, owner and hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      read_r  <= 1'b0;
      hold_r  <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_r <= lsu_acc_s;
        read_r  <= win_read_s;
      end else begin
        owner_r <= owner_r;
        read_r  <= read_r;
      end
      if ((state_r == RSP) && !rsp_hs_s) begin
        hold_r <= read_r ? itcm_ram_dout : {DW{1'b0}};
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Response routing: data only for reads, zero otherwise
  always_comb begin
    rsp_data_s = {DW{1'b0}};
    case (state_r)
      RSP:     rsp_data_s = read_r ? itcm_ram_dout : {DW{1'b0}};
      HOLD:    rsp_data_s = read_r ? hold_r : {DW{1'b0}};
      default: rsp_data_s = {DW{1'b0}};
    endcase
  end

  assign ifu2itcm_rsp_valid = pending_s & ~owner_r;
  assign lsu2itcm_rsp_valid = pending_s & owner_r;
  assign ifu2itcm_rsp_rdata = ifu2itcm_rsp_valid ? rsp_data_s : {DW{1'b0}};
  assign lsu2itcm_rsp_rdata = lsu2itcm_rsp_valid ? rsp_data_s : {DW{1'b0}};

endmodule

// File: tb/tb_itcm_arb.sv
// Directed self-checking bench for itcm_arb with a behavioural 1-cycle-latency RAM.
module tb_itcm_arb;
  localparam int AW = 16, RAW = 14, DW = 32, MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ifu_cv, ifu_cr, ifu_rd, ifu_rv, ifu_rr, lsu_cv, lsu_cr, lsu_rd, lsu_rv, lsu_rr;
  logic [AW-1:0] ifu_a, lsu_a;
  logic [MW-1:0] ifu_m, lsu_m;
  logic [DW-1:0] ifu_wd, lsu_wd, ifu_rdat, lsu_rdat;
  logic ram_cs, ram_we;
  logic [RAW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout, wr_word;
  logic [31:0] mem [0:255];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  itcm_arb #(
    .AW(AW), .RAW(RAW), .DW(DW), .MW(MW),
`ifdef ITCM_ARB_STARVE_EN
    .STARVE_MAX(2)
`else
    .STARVE_MAX(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu2itcm_cmd_valid(ifu_cv), .ifu2itcm_cmd_ready(ifu_cr), .ifu2itcm_cmd_read(ifu_rd),
    .ifu2itcm_cmd_addr(ifu_a), .ifu2itcm_cmd_wmask(ifu_m), .ifu2itcm_cmd_wdata(ifu_wd),
    .ifu2itcm_rsp_valid(ifu_rv), .ifu2itcm_rsp_ready(ifu_rr), .ifu2itcm_rsp_rdata(ifu_rdat),
    .lsu2itcm_cmd_valid(lsu_cv), .lsu2itcm_cmd_ready(lsu_cr), .lsu2itcm_cmd_read(lsu_rd),
    .lsu2itcm_cmd_addr(lsu_a), .lsu2itcm_cmd_wmask(lsu_m), .lsu2itcm_cmd_wdata(lsu_wd),
    .lsu2itcm_rsp_valid(lsu_rv), .lsu2itcm_rsp_ready(lsu_rr), .lsu2itcm_rsp_rdata(lsu_rdat),
    .itcm_ram_cs(ram_cs), .itcm_ram_we(ram_we), .itcm_ram_addr(ram_addr),
    .itcm_ram_wem(ram_wem), .itcm_ram_din(ram_din), .itcm_ram_dout(ram_dout)
  );

  // RAM model: byte-masked write, dout valid only the cycle after cs (junk otherwise)
  always_comb begin
    wr_word = mem[ram_addr[7:0]];
    for (int b = 0; b < 4; b++)
      if (ram_wem[b]) wr_word[8*b +: 8] = ram_din[8*b +: 8];
  end

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr[7:0]] <= wr_word;
      ram_dout <= mem[ram_addr[7:0]];
    end else begin
      ram_dout <= 32'hBAD0_BAD0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_cv = 1'b0; ifu_rd = 1'b1; ifu_a = 16'h0000; ifu_m = 4'h0; ifu_wd = 32'h0;
    lsu_cv = 1'b0; lsu_rd = 1'b1; lsu_a = 16'h0000; lsu_m = 4'h0; lsu_wd = 32'h0;
    ifu_rr = 1'b1; lsu_rr = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    ifu_cv = 1'b1; lsu_cv = 1'b1;
    #12;
    vecs++; if (ifu_cr !== 1'b0 || lsu_cr !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b%b want 00", ifu_cr, lsu_cr); end
    vecs++; if (ifu_rv !== 1'b0 || lsu_rv !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid: got %b%b want 00", ifu_rv, lsu_rv); end
    vecs++; if (ifu_rdat !== 32'h0 || lsu_rdat !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h %h want 0", ifu_rdat, lsu_rdat); end
    vecs++; if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin errs++; $display("FAIL reset_ram: got cs=%b we=%b want 0 0", ram_cs, ram_we); end
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_ifu_read();
    ifu_cv = 1'b1; ifu_rd = 1'b1; ifu_a = 16'h0010; ifu_m = 4'hF;
    #1;
    vecs++; if (ifu_cr !== 1'b1) begin errs++; $display("FAIL ifu_read_ready: got %b want 1", ifu_cr); end
    vecs++; if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_wem !== 4'h0) begin errs++; $display("FAIL ifu_read_ram_ctl: got cs=%b we=%b wem=%h want 1 0 0", ram_cs, ram_we, ram_wem); end
    vecs++; if (ram_addr !== 14'd4) begin errs++; $display("FAIL ifu_read_addr: got %0d want 4", ram_addr); end
    tick();
    idle_inputs();
    #1;
    vecs++; if (ifu_rv !== 1'b1 || lsu_rv !== 1'b0) begin errs++; $display("FAIL ifu_read_rsp_valid: got ifu=%b lsu=%b want 1 0", ifu_rv, lsu_rv); end
    vecs++; if (ifu_rdat !== 32'hDEADBEEF) begin errs++; $display("FAIL ifu_read_rdata: got %h want deadbeef", ifu_rdat); end
    tick();
    #1;
    vecs++; if (ifu_rv !== 1'b0) begin errs++; $display("FAIL ifu_read_idle: got %b want 0", ifu_rv); end
  endtask

  task automatic test_priority();
    ifu_cv = 1'b1; ifu_a = 16'h0010; lsu_cv = 1'b1; lsu_a = 16'h000C;
    #1;
    vecs++; if (lsu_cr !== 1'b1 || ifu_cr !== 1'b0) begin errs++; $display("FAIL prio_grant: got lsu=%b ifu=%b want 1 0", lsu_cr, ifu_cr); end
    vecs++; if (ram_addr !== 14'd3) begin errs++; $display("FAIL prio_addr: got %0d want 3", ram_addr); end
    tick();
    lsu_cv = 1'b0;
    #1;
    vecs++; if (lsu_rv !== 1'b1 || lsu_rdat !== 32'h0BADCAFE) begin errs++; $display("FAIL prio_lsu_rsp: got v=%b d=%h want 1 0badcafe", lsu_rv, lsu_rdat); end
    vecs++; if (ifu_cr !== 1'b1 || ram_addr !== 14'd4) begin errs++; $display("FAIL prio_ifu_b2b: got ready=%b addr=%0d want 1 4", ifu_cr, ram_addr); end
    tick();
    idle_inputs();
    #1;
    vecs++; if (ifu_rv !== 1'b1 || lsu_rv !== 1'b0 || ifu_rdat !== 32'hDEADBEEF) begin errs++; $display("FAIL prio_ifu_rsp: got v=%b/%b d=%h want 1/0 deadbeef", ifu_rv, lsu_rv, ifu_rdat); end
    tick();
  endtask

  task automatic test_write_read();
    lsu_cv = 1'b1; lsu_rd = 1'b0; lsu_a = 16'h0020; lsu_m = 4'hF; lsu_wd = 32'h12345678;
    #1;
    vecs++; if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_wem !== 4'hF) begin errs++; $display("FAIL wr_ctl: got cs=%b we=%b wem=%h want 1 1 f", ram_cs, ram_we, ram_wem); end
    vecs++; if (ram_addr !== 14'd8 || ram_din !== 32'h12345678) begin errs++; $display("FAIL wr_addr_din: got %0d %h want 8 12345678", ram_addr, ram_din); end
    tick();
    idle_inputs();
    ifu_cv = 1'b1; ifu_a = 16'h0020;
    #1;
    vecs++; if (lsu_rv !== 1'b1 || lsu_rdat !== 32'h0) begin errs++; $display("FAIL wr_rsp: got v=%b d=%h want 1 0", lsu_rv, lsu_rdat); end
    vecs++; if (ifu_cr !== 1'b1) begin errs++; $display("FAIL wr_then_rd_ready: got %b want 1", ifu_cr); end
    tick();
    idle_inputs();
    #1;
    vecs++; if (ifu_rv !== 1'b1 || ifu_rdat !== 32'h12345678) begin errs++; $display("FAIL rd_after_wr: got v=%b d=%h want 1 12345678", ifu_rv, ifu_rdat); end
    tick();
  endtask

  task automatic test_hold();
    lsu_cv = 1'b1; lsu_a = 16'h000C; lsu_rr = 1'b0;
    #1;
    vecs++; if (lsu_cr !== 1'b1) begin errs++; $display("FAIL hold_accept: got %b want 1", lsu_cr); end
    tick();
    ifu_cv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (lsu_rv !== 1'b1 || lsu_rdat !== 32'h0BADCAFE) begin errs++; $display("FAIL hold_rsp[%0d]: got v=%b d=%h want 1 0badcafe", i, lsu_rv, lsu_rdat); end
      vecs++; if (ifu_cr !== 1'b0 || lsu_cr !== 1'b0 || ram_cs !== 1'b0) begin errs++; $display("FAIL hold_block[%0d]: got ifu=%b lsu=%b cs=%b want 0 0 0", i, ifu_cr, lsu_cr, ram_cs); end
      tick();
    end
    idle_inputs();
    #1;
    vecs++; if (lsu_rv !== 1'b1 || lsu_rdat !== 32'h0BADCAFE) begin errs++; $display("FAIL hold_release: got v=%b d=%h want 1 0badcafe", lsu_rv, lsu_rdat); end
    tick();
    #1;
    vecs++; if (lsu_rv !== 1'b0) begin errs++; $display("FAIL hold_done: got %b want 0", lsu_rv); end
  endtask

  task automatic test_arbitration();
    logic exp_lsu, prev_lsu;
    prev_lsu = 1'b0;
    ifu_cv = 1'b1; ifu_a = 16'h0010; lsu_cv = 1'b1; lsu_a = 16'h000C;
    for (int i = 0; i < 6; i++) begin
`ifdef ITCM_ARB_STARVE_EN
      exp_lsu = ((i % 3) != 2);
`else
      exp_lsu = 1'b1;
`endif
      #1;
      vecs++; if (lsu_cr !== exp_lsu || ifu_cr !== !exp_lsu || ram_cs !== 1'b1) begin errs++; $display("FAIL arb_grant[%0d]: got lsu=%b ifu=%b cs=%b want %b %b 1", i, lsu_cr, ifu_cr, ram_cs, exp_lsu, !exp_lsu); end
      if (i > 0) begin
        vecs++; if (lsu_rv !== prev_lsu || ifu_rv !== !prev_lsu) begin errs++; $display("FAIL arb_owner[%0d]: got lsu=%b ifu=%b want %b %b", i, lsu_rv, ifu_rv, prev_lsu, !prev_lsu); end
      end
      prev_lsu = exp_lsu;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    ifu_cv = 1'b1; ifu_a = 16'h0010;
    tick();
    idle_inputs();
    #1;
    vecs++; if (ifu_rv !== 1'b1) begin errs++; $display("FAIL rstmid_pre: got %b want 1", ifu_rv); end
    rst_n = 1'b0;
    #1;
    vecs++; if (ifu_rv !== 1'b0 || ifu_rdat !== 32'h0 || ram_cs !== 1'b0) begin errs++; $display("FAIL rstmid_async: got v=%b d=%h cs=%b want 0 0 0", ifu_rv, ifu_rdat, ram_cs); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++; if (ifu_rv !== 1'b0 || lsu_rv !== 1'b0) begin errs++; $display("FAIL rstmid_spurious[%0d]: got %b%b want 00", i, ifu_rv, lsu_rv); end
      tick();
    end
    lsu_cv = 1'b1; lsu_a = 16'h0010;
    #1;
    vecs++; if (lsu_cr !== 1'b1) begin errs++; $display("FAIL rstmid_accept: got %b want 1", lsu_cr); end
    tick();
    idle_inputs();
    #1;
    vecs++; if (lsu_rv !== 1'b1 || lsu_rdat !== 32'hDEADBEEF) begin errs++; $display("FAIL rstmid_rsp: got v=%b d=%h want 1 deadbeef", lsu_rv, lsu_rdat); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[3] = 32'h0BADCAFE;
    mem[4] = 32'hDEADBEEF;
    test_reset();
    test_ifu_read();
    test_priority();
    test_write_read();
    test_hold();
    test_arbitration();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
